// File: rtl/score_display_scan_pkg.sv
// Shared definitions for the score display: active-low segment patterns (dp off),
// converter FSM state encodings, default scan divider and a display-range helper.
package score_display_scan_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int DEF_TICK_DIV = 50000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [7:0] seg_lookup(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Largest value representable on the given number of decimal digits.
  function automatic logic [63:0] max_display(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/score_display_scan_bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one bit per cycle for BIN_W cycles after start.
// done marks the final iteration cycle (bcd valid next cycle); start is ignored while busy.
module bin2bcd_seq #(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end

    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      bin_d = bin_q << 1;
      bcd_d = (adj << 1) | BCD_W'(bin_q[BIN_W-1]);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(BIN_W - 1)) busy_d = 1'b0;
    end else if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(BIN_W - 1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_display_scan.sv
// Scanned 7-segment score display: load -> done after BIN_W+1 cycles, loads while busy are dropped,
// digits change atomically after commit. SEG_BLINK_EN adds a blink input that blanks alternate windows.
module score_display_scan
  import score_display_scan_pkg::*;
#(
`ifdef SEG_BLINK_EN
  parameter int BLINK_TICKS = 64,
`endif
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int LZB        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SEG_BLINK_EN
  input  logic                  blink,
`endif
  input  logic [BIN_W-1:0]      value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int          TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam logic [63:0] MAX_VAL = max_display(NUM_DIGITS);

  conv_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0] digits_q, digits_d;

  logic             sat;
  logic [BIN_W-1:0] conv_bin;
  logic             conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;

  assign sat      = 64'(value) > MAX_VAL;
  assign conv_bin = sat ? MAX_VAL[BIN_W-1:0] : value;

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    conv_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load && !conv_busy) begin
          conv_start = 1'b1;
          state_d    = ST_CONV;
          busy_d     = 1'b1;
          ovf_pend_d = sat;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          state_d = ST_COMMIT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_COMMIT: begin
        // Digits land at the end of this cycle so a coinciding tick still sees the old value.
        state_d  = ST_IDLE;
        digits_d = conv_bcd;
        ovf_d    = ovf_pend_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
    end
  end

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic                  tick;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  blink_off;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

`ifdef SEG_BLINK_EN
  localparam int BKW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [BKW-1:0] blink_cnt_q, blink_cnt_d;
  logic           phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      if (blink_cnt_q == BKW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BKW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_off = blink && phase_q;
`else
  assign blink_off = 1'b0;
`endif

  logic [3:0]            dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lead_blank;
  logic [7:0]            cur_lut;
  logic                  slot_blank;

  // Walk from the top digit down; a digit is leading-blank until the first non-zero is seen.
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig[i]        = digits_q[4*i +: 4];
      seen          = seen | (dig[i] != 4'd0);
      lead_blank[i] = (LZB != 0) && (i != 0) && !seen;
    end
  end

  always_comb begin
    cur_lut    = seg_lookup(dig[idx_q]);
    slot_blank = lead_blank[idx_q] || blink_off;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    idx_d      = idx_q;
    seg_d      = seg_q;
    an_d       = an_q;
    if (tick) begin
      idx_d = (idx_q == '0) ? IW'(NUM_DIGITS - 1) : idx_q - IW'(1);
      if (slot_blank) begin
        seg_d = SEG_BLANK;
        an_d  = '1;
      end else begin
        seg_d = (cur_lut == SEG_BLANK) ? SEG_BLANK : {~dp_mask[idx_q], cur_lut[6:0]};
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      idx_q      <= IW'(NUM_DIGITS - 1);
      seg_q      <= SEG_BLANK;
      an_q       <= '1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Bench for score_display_scan: two instances (blanking on/off) driven together, checked every cycle
// against an arithmetic model of committed value, scan position and conversion timing.
module tb_score_display_scan;

  localparam int ND   = 4;
  localparam int BW   = 14;
  localparam int TD   = 4;
  localparam int MAXV = 9999;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [BW-1:0] value = '0;
  logic [ND-1:0] dp_mask = '0;

  logic          busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [7:0]    seg_a, seg_b;
  logic [ND-1:0] an_a, an_b;

  always #5 clk = ~clk;

  score_display_scan #(.NUM_DIGITS(ND), .BIN_W(BW), .TICK_DIV(TD), .LZB(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .seg(seg_a), .an(an_a)
  );

  score_display_scan #(.NUM_DIGITS(ND), .BIN_W(BW), .TICK_DIV(TD), .LZB(0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .seg(seg_b), .an(an_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            e;
  int            conv_edge;
  bit            active;
  int            pend_v, comm_v;
  bit            pend_ovf, comm_ovf;
  int            midx;
  logic [7:0]    exp_seg [2];
  logic [ND-1:0] exp_an  [2];
  logic [7:0]    seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Expected {an, seg} for decimal digit i of value v.
  function automatic logic [ND+7:0] slot(int v, int i, bit lzb, logic [ND-1:0] dp);
    int p;
    int d;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    d = (v / p) % 10;
    if (lzb && i > 0 && v < p) return {{ND{1'b1}}, 8'hFF};
    return {~(ND'(1) << i), ~dp[i], seg_tab[d][6:0]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp_v, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      e = 0; active = 0; comm_v = 0; comm_ovf = 0; midx = ND - 1;
      for (int k = 0; k < 2; k++) begin
        exp_seg[k] = 8'hFF;
        exp_an[k]  = '1;
      end
    end else begin
      e++;
      if (e % TD == 0) begin
        {exp_an[0], exp_seg[0]} = slot(comm_v, midx, 1'b1, dp_mask);
        {exp_an[1], exp_seg[1]} = slot(comm_v, midx, 1'b0, dp_mask);
        midx = (midx == 0) ? ND - 1 : midx - 1;
      end
      if (load && !active) begin
        active    = 1;
        conv_edge = e;
        pend_ovf  = (int'(value) > MAXV);
        pend_v    = pend_ovf ? MAXV : int'(value);
      end
      if (active && e == conv_edge + BW + 1) begin
        comm_v   = pend_v;
        comm_ovf = pend_ovf;
        active   = 0;
      end
    end
    #1;
    check("seg_lzb",    32'(seg_a), 32'(exp_seg[0]));
    check("an_lzb",     32'(an_a),  32'(exp_an[0]));
    check("seg_nolzb",  32'(seg_b), 32'(exp_seg[1]));
    check("an_nolzb",   32'(an_b),  32'(exp_an[1]));
    check("busy_lzb",   32'(busy_a), 32'(active && e >= conv_edge && e < conv_edge + BW));
    check("busy_nolzb", 32'(busy_b), 32'(active && e >= conv_edge && e < conv_edge + BW));
    check("done_lzb",   32'(done_a), 32'(active && e == conv_edge + BW));
    check("done_nolzb", 32'(done_b), 32'(active && e == conv_edge + BW));
    check("ovf_lzb",    32'(ovf_a), 32'(comm_ovf));
    check("ovf_nolzb",  32'(ovf_b), 32'(comm_ovf));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(int v);
    value = BW'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(20);

    do_load(1234);
    run(40);

    dp_mask = 4'b0010;
    do_load(42);
    run(40);

    dp_mask = 4'b0000;
    do_load(12000);
    run(30);
    do_load(5);
    run(30);

    // Load while busy, then reset mid-conversion, then reload.
    do_load(777);
    run(2);
    do_load(111);
    run(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(20);
    do_load(777);
    run(30);

    // Load in the commit cycle is dropped, the one right after is taken.
    do_load(321);
    run(BW);
    do_load(654);
    do_load(987);
    run(40);

    for (int r = 0; r < 800; r++) begin
      case ($urandom_range(0, 3))
        0:       value = BW'($urandom_range(0, 9));
        1:       value = BW'($urandom_range(0, 999));
        2:       value = BW'($urandom_range(9990, 10010));
        default: value = BW'($urandom_range(0, 16383));
      endcase
      dp_mask = ND'($urandom);
      load    = ($urandom_range(0, 11) == 0);
      step();
    end
    load = 1'b0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
